// File: rtl/slave_stream_s00_axis.sv
// AXI4-Stream slave front end: two-entry skid buffer feeding the stream FIFO,
// with accepted-beat and packet counters.
//
// state | meaning
// EMPTY | no beat buffered
// ONE   | one beat in main register
// TWO   | main and skid registers both hold beats; TREADY held low
module slave_stream_s00_axis #(
   parameter int C_S_AXIS_TDATA_WIDTH = 32
) (
   input  logic                            S_AXIS_ACLK,
   input  logic                            S_AXIS_ARESETN,
   input  logic                            S_AXIS_TVALID,
   input  logic [C_S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
   input  logic                            S_AXIS_TLAST,
   output logic                            S_AXIS_TREADY,
   output logic                            fifo_wr_en,
   output logic [C_S_AXIS_TDATA_WIDTH-1:0] fifo_wr_data,
   input  logic                            fifo_full,
   input  logic                            enable,
   input  logic                            cnt_clr,
   output logic [31:0]                     beat_count,
   output logic [15:0]                     pkt_count
);

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   state_t                          state_q, state_d;
   logic [C_S_AXIS_TDATA_WIDTH-1:0] main_q, main_d;
   logic [C_S_AXIS_TDATA_WIDTH-1:0] skid_q, skid_d;
   logic                            tready_q;
   logic [31:0]                     beat_cnt_q;
   logic [15:0]                     pkt_cnt_q;
   logic                            accept;
   logic                            drain;

   assign accept        = S_AXIS_TVALID & tready_q;
   assign drain         = (state_q != EMPTY) & ~fifo_full;
   assign fifo_wr_en    = drain;
   assign fifo_wr_data  = main_q;
   assign S_AXIS_TREADY = tready_q;
   assign beat_count    = beat_cnt_q;
   assign pkt_count     = pkt_cnt_q;

   always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
      if (!S_AXIS_ARESETN) begin
         state_q  <= EMPTY;
         main_q   <= '0;
         skid_q   <= '0;
         tready_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         main_q   <= main_d;
         skid_q   <= skid_d;
         tready_q <= (state_d != TWO) & enable;
      end
   end

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d = ONE;
               main_d  = S_AXIS_TDATA;
            end
         end
         ONE: begin
            if (accept && drain) begin
               main_d = S_AXIS_TDATA;
            end else if (accept) begin
               state_d = TWO;
               skid_d  = S_AXIS_TDATA;
            end else if (drain) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            // TREADY is low here, so only a drain can move the buffer
            if (drain) begin
               state_d = ONE;
               main_d  = skid_q;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
      if (!S_AXIS_ARESETN) begin
         beat_cnt_q <= '0;
         pkt_cnt_q  <= '0;
      end else if (cnt_clr) begin
         beat_cnt_q <= '0;
         pkt_cnt_q  <= '0;
      end else if (accept) begin
         beat_cnt_q <= beat_cnt_q + 32'd1;
         if (S_AXIS_TLAST) begin
            pkt_cnt_q <= pkt_cnt_q + 16'd1;
         end
      end
   end

endmodule
